// File: rtl/mastermind_pkg.sv
// rtl/mastermind_pkg.sv - shared colours, peg geometry and screen widths
package mastermind_pkg;
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] GREEN = 3'b010;

  localparam int PEGS_PER_ROW = 4;
  localparam int PEG_SIZE     = 5;
  localparam int X_W          = 8;
  localparam int Y_W          = 7;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} draw_state_t;

  // Black pegs come first, then white, then green fills the remainder.
  function automatic logic [2:0] peg_color(input logic [1:0] peg,
                                           input logic [2:0] place_thr,
                                           input logic [2:0] sum_thr);
    if ({1'b0, peg} < place_thr) return BLACK;
    if ({1'b0, peg} < sum_thr)   return WHITE;
    return GREEN;
  endfunction
endpackage

// File: rtl/peg_raster_counter.sv
// rtl/peg_raster_counter.sv - px/py/peg nested raster counter for one feedback row
module peg_raster_counter
  import mastermind_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       advance,
  output logic [2:0] px,
  output logic [2:0] py,
  output logic [1:0] peg,
  output logic       last
);
  localparam logic [2:0] PX_MAX  = 3'(PEG_SIZE - 1);
  localparam logic [1:0] PEG_MAX = 2'(PEGS_PER_ROW - 1);

  assign last = (px == PX_MAX) && (py == PX_MAX) && (peg == PEG_MAX);

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      px  <= '0;
      py  <= '0;
      peg <= '0;
    end else if (advance) begin
      if (px == PX_MAX) begin
        px <= '0;
        if (py == PX_MAX) begin
          py  <= '0;
          peg <= peg + 2'd1;
        end else begin
          py <= py + 3'd1;
        end
      end else begin
        px <= px + 3'd1;
      end
    end
  end
endmodule

// File: rtl/feedback_draw_ctrl.sv
// rtl/feedback_draw_ctrl.sv - draws one row of four 5x5 feedback pegs through the VGA plot port
module feedback_draw_ctrl
  import mastermind_pkg::*;
#(
  parameter int NUM_ROWS  = 10,
  parameter int X_BASE    = 128,
  parameter int Y_BASE    = 5,
  parameter int PEG_PITCH = 6,
  parameter int ROW_PITCH = 10
)
(
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [3:0]     row,
  input  logic [2:0]     c_place,
  input  logic [2:0]     c_color,
  input  logic           ready,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     color,
  output logic           plot,
  output logic           busy,
  output logic           done
);
  localparam logic [3:0] ROW_LIM = 4'(NUM_ROWS);

  draw_state_t r_state;
  logic [3:0]  r_row;
  logic [2:0]  r_place_thr;
  logic [2:0]  r_sum_thr;
  logic        r_final;

  logic       w_start_ok, w_clear, w_adv, w_last;
  logic [2:0] w_px, w_py, w_cnt_px, w_cnt_py;
  logic [1:0] w_peg, w_cnt_peg;
  logic [3:0] w_row, w_in_sum4;
  logic [2:0] w_in_place, w_in_sum, w_place, w_sum;
  logic [X_W-1:0] w_x;
  logic [Y_W-1:0] w_y;
  logic [2:0]     w_color;

  assign w_start_ok = (r_state == S_IDLE) && start && (row < ROW_LIM);
  assign w_in_place = (c_place > 3'd4) ? 3'd4 : c_place;
  assign w_in_sum4  = {1'b0, c_place} + {1'b0, c_color};
  assign w_in_sum   = (w_in_sum4 > 4'd4) ? 3'd4 : w_in_sum4[2:0];

  // Counter sits one pixel ahead of the outputs, so a start loads pixel 0
  // directly and the counter moves to pixel 1 in the same edge.
  assign w_clear = (r_state != S_DRAW) && !w_start_ok;
  assign w_adv   = w_start_ok || ((r_state == S_DRAW) && ready);

  peg_raster_counter u_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (w_clear),
    .advance (w_adv),
    .px      (w_cnt_px),
    .py      (w_cnt_py),
    .peg     (w_cnt_peg),
    .last    (w_last)
  );

  assign w_px    = (r_state == S_IDLE) ? 3'd0 : w_cnt_px;
  assign w_py    = (r_state == S_IDLE) ? 3'd0 : w_cnt_py;
  assign w_peg   = (r_state == S_IDLE) ? 2'd0 : w_cnt_peg;
  assign w_row   = (r_state == S_IDLE) ? row : r_row;
  assign w_place = (r_state == S_IDLE) ? w_in_place : r_place_thr;
  assign w_sum   = (r_state == S_IDLE) ? w_in_sum : r_sum_thr;

  // Modular add in the output width is the same as wide-then-truncate.
  assign w_x = X_W'(X_BASE) + X_W'(w_peg) * X_W'(PEG_PITCH) + X_W'(w_px);
  assign w_y = Y_W'(Y_BASE) + Y_W'(w_row) * Y_W'(ROW_PITCH) + Y_W'(w_py);
  assign w_color = peg_color(w_peg, w_place, w_sum);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_place_thr <= '0;
      r_sum_thr   <= '0;
      r_final     <= 1'b0;
      x           <= '0;
      y           <= '0;
      color       <= GREEN;
      plot        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (w_start_ok) begin
            r_row       <= row;
            r_place_thr <= w_in_place;
            r_sum_thr   <= w_in_sum;
            r_final     <= 1'b0;
            x           <= w_x;
            y           <= w_y;
            color       <= w_color;
            plot        <= 1'b1;
            busy        <= 1'b1;
            r_state     <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (ready) begin
            if (r_final) begin
              plot    <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              x       <= w_x;
              y       <= w_y;
              color   <= w_color;
              r_final <= w_last;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_feedback_draw_ctrl.sv
// tb/tb_feedback_draw_ctrl.sv - self-checking bench for feedback_draw_ctrl
module tb_feedback_draw_ctrl;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       ready = 1'b1;
  logic [3:0] row = '0;
  logic [2:0] c_place = '0;
  logic [2:0] c_color = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;
  logic       plot, busy, done;

  always #5 clk = ~clk;

  feedback_draw_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start), .row(row),
    .c_place(c_place), .c_color(c_color), .ready(ready),
    .x(x), .y(y), .color(color), .plot(plot), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {int x; int y; int c;} pix_t;

  // Pixel n of a row drawing, straight from the geometry and peg rules.
  function automatic pix_t ref_pixel(input int r, input int cp, input int cc, input int n);
    pix_t p;
    int peg, py, px, blacks, marked;
    peg = n / 25; py = (n % 25) / 5; px = n % 5;
    blacks = (cp > 4) ? 4 : cp;
    marked = (cp + cc > 4) ? 4 : cp + cc;
    p.x = 128 + peg * 6 + px;
    p.y = (5 + r * 10 + py) % 128;
    p.c = (peg < blacks) ? 0 : (peg < marked) ? 7 : 2;
    return p;
  endfunction

  bit m_live = 0, m_active = 0, m_done = 0, m_rst = 1;
  int m_idx = 0, m_row = 0, m_cp = 0, m_cc = 0, cyc = 0;
  bit rnd_ready = 0;

  always @(posedge clk) begin
    cyc++;
    m_live = 1;
    if (!resetn) begin
      m_active = 0; m_done = 0; m_rst = 1; m_idx = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      if (ready) begin
        m_idx++;
        if (m_idx == 100) begin m_active = 0; m_done = 1; end
      end
    end else if (start && row < 10) begin
      m_active = 1; m_idx = 0; m_rst = 0;
      m_row = row; m_cp = c_place; m_cc = c_color;
    end
  end

  always @(negedge clk) begin
    pix_t p;
    if (m_live) begin
      chk("plot", plot, m_active);
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      if (m_active) begin
        p = ref_pixel(m_row, m_cp, m_cc, m_idx);
        chk("x", x, p.x);
        chk("y", y, p.y);
        chk("color", color, p.c);
      end else if (m_rst) begin
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_color", color, 2);
      end
    end
  end

  always @(negedge clk) ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;

  task automatic start_draw(input int r, input int cp, input int cc);
    @(negedge clk);
    start = 1'b1; row = 4'(r); c_place = 3'(cp); c_color = 3'(cc);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    pix_t p;
    int t0;
    bit hit;

    p = ref_pixel(0, 2, 1, 0);
    chk("ref_first_x", p.x, 128); chk("ref_first_y", p.y, 5); chk("ref_first_c", p.c, 0);
    p = ref_pixel(0, 2, 1, 99);
    chk("ref_last_x", p.x, 150); chk("ref_last_y", p.y, 9); chk("ref_last_c", p.c, 2);
    p = ref_pixel(0, 2, 1, 50); chk("ref_peg2_c", p.c, 7);
    p = ref_pixel(9, 0, 0, 99); chk("ref_row9_y", p.y, 99);
    p = ref_pixel(0, 0, 0, 25); chk("ref_gap_x", p.x, 134);
    p = ref_pixel(0, 4, 3, 80); chk("ref_ovf_c", p.c, 0);
    p = ref_pixel(0, 1, 5, 30); chk("ref_c15_c", p.c, 7);

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    @(negedge clk);
    start = 1'b1; row = 4'd0; c_place = 3'd2; c_color = 3'd1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("start_to_done", cyc - t0, 101);

    start_draw(9, 0, 0); wait_done();
    start_draw(0, 4, 3); wait_done();
    start_draw(0, 1, 5); wait_done();

    rnd_ready = 1;
    start_draw(3, 2, 2); wait_done();
    start_draw(7, 1, 3); wait_done();
    rnd_ready = 0;

    start_draw(1, 1, 1);
    repeat (20) @(negedge clk);
    start = 1'b1; row = 4'd5; c_place = 3'd4; c_color = 3'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    start = 1'b1; row = 4'd2; c_place = 3'd3; c_color = 3'd0;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_busy", busy, 0);
    start_draw(10, 1, 1);
    repeat (3) @(negedge clk);
    chk("row10_busy", busy, 0);

    start_draw(4, 2, 2);
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      if (m_idx == 37) hit = 1;
      else @(negedge clk);
    end
    chk("reach_pixel37", hit, 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_plot", plot, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    start_draw(4, 2, 2); wait_done();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/feedback_draw_ctrl.md
# feedback_draw_ctrl

Sequencer that draws one guess row's four feedback pegs on the 160x120 VGA framebuffer. On a start pulse it latches the row index and the scored counts (correct place, correct colour), then walks 4 pegs × 5×5 pixels. It emits one pixel per accepted cycle: black for each correct place, white for each correct colour, green for the rest. It sits between the scoring logic and the shared VGA plot port, and obeys that port's ready back-pressure.

## Interface
- NUM_ROWS, 10: number of guess rows; valid row indices are 0..NUM_ROWS-1.
- X_BASE, 128: x pixel of peg 0, column 0.
- Y_BASE, 5: y pixel of row 0, line 0.
- PEG_PITCH, 6: x distance between peg origins (1-pixel undrawn gap).
- ROW_PITCH, 10: y distance between row origins.
- clk  in  1  system clock.
- resetn  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request to draw a row; honoured only in IDLE.
- row  in  4  guess row index, sampled with start.
- c_place  in  3  correct-place count, sampled with start.
- c_color  in  3  correct-colour count, sampled with start.
- ready  in  1  VGA port accepts the current pixel this cycle.
- x  out  8  pixel x.
- y  out  7  pixel y.
- color  out  3  pixel colour: black 3'b000, white 3'b111, green 3'b010.
- plot  out  1  x/y/color valid.
- busy  out  1  drawing in progress.
- done  out  1  one-cycle pulse after the final pixel is accepted.

## Operation
- States:
  - IDLE: start=1 with row<NUM_ROWS latches row, c_place, c_color and goes to DRAW. start with row≥NUM_ROWS is ignored; stay in IDLE.
  - DRAW: plot=1, busy=1. Counters px, py (0..4) and peg (0..3).
  - DONE: done=1 for one cycle, then IDLE.
- Counter advance in DRAW happens only when plot&&ready. Order: px fastest, then py, then peg. The last pixel is peg=3, py=4, px=4; once accepted, go to DONE.
- Colour thresholds: sum = c_place + c_color, computed 4 bits wide and clamped to 4. Place threshold = min(c_place,4).
- Peg colour: peg < place threshold → black; else peg < sum → white; else green.
- x = X_BASE + peg*PEG_PITCH + px.
- y = Y_BASE + row*ROW_PITCH + py, computed wide and truncated to 7 bits. The defaults keep the maximum at 99.
- start, row and count inputs are ignored while in DRAW or DONE. The latched values are stable for the whole draw.
- x, y and color are held unchanged while ready=0 (no pixel drop, no duplication).

## Timing
- Reset values: x=0, y=0, color=green, plot=0, busy=0, done=0, state IDLE, all counters 0.
- resetn=0 mid-draw aborts the draw at the next edge. No done pulse is produced.
- Latency: start sampled at edge N → first pixel (peg0, px0, py0) on x/y/color with plot=1 and busy=1 from edge N.
- With ready held at 1, pixels are accepted on 100 consecutive cycles. done is high in the cycle after the last acceptance, with busy=0 and plot=0 in that cycle.
- Start→done is 101 cycles when ready is constant 1. Each ready=0 cycle in DRAW adds one cycle.
- The earliest new start is accepted in the cycle after done (back in IDLE). A start coincident with done is ignored.
- All outputs are registered; there is no combinational path from ready or start to any output.

## Structure
- Shared package `mastermind_pkg`: colour constants BLACK/WHITE/GREEN, PEGS_PER_ROW=4, PEG_SIZE=5, screen widths (X_W=8, Y_W=7).
- One sub-module, `peg_raster_counter`: the px/py/peg nested counter. Inputs are clear and advance; outputs are px, py, peg and last.
- This module holds the FSM, input latches, colour select and address arithmetic.

## Test plan
- Reset, then start, row=0, c_place=2, c_color=1, ready=1 → 100 pixels. Pegs 0–1 black, peg 2 white, peg 3 green. First pixel (128,5), last pixel (150,9). done at cycle 101.
- row=9, c_place=0, c_color=0 → all 100 pixels green, y spans 95..99, x spans 128..150 with gap columns 133/139/145 never plotted.
- c_place=4, c_color=3 (overflow) → all pegs black, no white, no wrap. Also c_place=1, c_color=5 → peg 0 black, pegs 1–3 white.
- ready toggled pseudo-randomly at about 50% → the exact 100-pixel sequence matches the ready=1 reference, x/y/color are stable while ready=0, and done follows the last accepted pixel by one cycle.
- start pulsed during DRAW and in the done cycle → ignored; latched values unchanged. Start with row=10 in IDLE → busy stays 0.
- resetn=0 at pixel 37 → the next cycle has plot=0, busy=0, outputs at reset values, and no done. A fresh start afterwards draws correctly from pixel 0.
